mod_reduce_stage: RTL and testbench
===================================

Name: mod_reduce_stage

Overview:
Third stage of the modular adder/subtractor, directly downstream of the 4-bit prefix adder.
- Captures the adder's 5-bit raw sum (s4..s0) and the add/sub tag supplied by the first stage.
- Reduces the sum modulo MOD to a 4-bit residue and flags out-of-range sums.
- Buffers results in a small FIFO with valid/ready handshakes on both sides, decoupling the combinational adder path from the consumer.

Parameters:
MOD, 13, modulus; legal range 2..16. Valid raw sums lie in 0..2*MOD-2.
DEPTH, 4, result FIFO depth in entries; power of two, 2..16.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  raw sum and tag are valid this cycle.
in_ready  output  1  stage can accept; equals !full, registered-derived, with no combinational path from out_ready.
in_sum  input  5  raw sum from prefix adder; bit 4 is the carry out.
in_sub  input  1  operation tag: 1 = subtraction, 0 = addition.
out_valid  output  1  FIFO head holds a result.
out_ready  input  1  consumer accepts the head this cycle.
out_res  output  4  reduced residue at FIFO head.
out_sub  output  1  operation tag at FIFO head.
out_err  output  1  head entry's raw sum was >= 2*MOD.
err_count  output  8  number of accepted out-of-range sums; saturates at 255.

Behaviour:
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Reduction is combinational on in_sum and is written into the FIFO on push:
  - in_sum < MOD: res = in_sum[3:0], err = 0.
  - MOD <= in_sum < 2*MOD: res = in_sum - MOD, truncated to 4 bits, err = 0.
  - in_sum >= 2*MOD: res = 0, err = 1.
- Tag in_sub is stored unchanged alongside res and err.
- Latency: an entry pushed at edge N is visible on out_* after edge N when the FIFO was empty. out_* is driven directly from FIFO storage at the read pointer.
- FIFO uses read and write pointers plus an occupancy counter of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
  - out_valid = !empty; in_ready = !full.
- Simultaneous push and pop:
  - Non-empty and not full: both pointers advance, occupancy unchanged.
  - Empty: pop is impossible since out_valid=0; push only.
  - Full: in_ready=0, so pop only. A full FIFO does not accept a push in the same cycle it is popped; in_ready rises the cycle after the pop.
- in_valid while in_ready=0: input ignored, nothing stored. The upstream must hold data (standard valid/ready).
- out_res, out_sub, out_err are don't-care when out_valid=0. The implementation holds the last storage contents; the testbench must not check them.
- err_count increments on each push with err=1 and saturates at 255 (no wrap).
- Reset (async, any time including mid-transfer):
  - Pointers and occupancy go to 0, so out_valid=0 and in_ready=1 (the cycle after reset deassertion).
  - err_count = 0.
  - Storage contents are not reset.
  - In-flight entries are discarded.
- No state machine beyond the FIFO control. DEPTH is checked at elaboration; MOD outside 2..16 is an elaboration error.

Test Plan:
1. MOD=13, out_ready=1, push in_sum=9, in_sub=0 -> next cycle out_valid=1, out_res=9, out_err=0, out_sub=0; FIFO empty after pop.
2. MOD=13, push in_sum=20 (0b10100), in_sub=1 -> out_res=7, out_sub=1, out_err=0. Push in_sum=13 -> out_res=0. Push in_sum=12 -> out_res=12.
3. MOD=13, push in_sum=26 then 31 -> both entries out_res=0, out_err=1; err_count=2. Then 300 error pushes -> err_count holds at 255.
4. DEPTH=4, out_ready=0, in_valid=1 with sums 1,2,3,4,5 -> first four accepted; in_ready=0 after the 4th. Raise out_ready -> pops 1,2,3,4 in order; sum 5 is accepted only after in_ready returns to 1.
5. Occupancy 2, in_valid=1 and out_ready=1 held for 10 cycles with sums 0..9 -> occupancy stays 2, outputs in order, no loss or duplication. Also cover pointer wrap past index 3.
6. FIFO holding 3 entries, err_count=5: assert rst asynchronously mid-cycle -> out_valid=0 immediately, err_count=0, in_ready=1 after release. The next push (in_sum=14) yields out_res=1.

Source files
------------

// File: rtl/mod_reduce_stage_if.sv
// mod_reduce_stage_if: the sum/tag input handshake, the result output handshake and the error counter of the reduce stage.
interface mod_reduce_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_sum;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic       out_sub;
    logic       out_err;
    logic [7:0] err_count;
    modport master (
        output in_valid, in_sum, in_sub, out_ready,
        input  in_ready, out_valid, out_res, out_sub, out_err, err_count
    );
    modport slave (
        input  in_valid, in_sum, in_sub, out_ready,
        output in_ready, out_valid, out_res, out_sub, out_err, err_count
    );
endinterface

// File: rtl/mod_reduce_stage.sv
// mod_reduce_stage: reduces a 5-bit raw sum modulo MOD and flags sums of 2*MOD or more.
// Results go through a DEPTH-entry FIFO, and the stage counts the out-of-range sums with a saturating counter.
module mod_reduce_stage #(
    parameter int MOD   = 13,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    mod_reduce_stage_if.slave s_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0]  L_MOD  = 5'(MOD);
    localparam logic [5:0]  L_TWO  = 6'(2 * MOD);
    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);
    if (MOD < 2 || MOD > 16) begin : g_bad_mod
        $fatal(1, "mod_reduce_stage: MOD must lie in 2..16");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "mod_reduce_stage: DEPTH must be a power of two in 2..16");
    end
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic [7:0]    r_errs;
    logic [3:0]    r_res [DEPTH];
    logic          r_sub [DEPTH];
    logic          r_err [DEPTH];
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_err;
    logic          w_wrap;
    logic [3:0]    w_res;
    always_comb begin
        w_full  = r_cnt == L_FULL;
        w_empty = r_cnt == '0;
        w_push  = s_bus.in_valid && !w_full;
        w_pop   = !w_empty && s_bus.out_ready;
        w_err   = {1'b0, s_bus.in_sum} >= L_TWO;
        w_wrap  = s_bus.in_sum >= L_MOD;
        w_res   = w_err ? 4'd0 : w_wrap ? 4'(s_bus.in_sum - L_MOD) : s_bus.in_sum[3:0];
    end
    // Storage is left unreset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_res[r_wr] <= w_res;
            r_sub[r_wr] <= s_bus.in_sub;
            r_err[r_wr] <= w_err;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_errs <= '0;
        end else begin
            r_wr   <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd   <= w_pop ? r_rd + 1'b1 : r_rd;
            r_cnt  <= (w_push && !w_pop) ? r_cnt + 1'b1 : (w_pop && !w_push) ? r_cnt - 1'b1 : r_cnt;
            r_errs <= (w_push && w_err && r_errs != 8'hFF) ? r_errs + 1'b1 : r_errs;
        end
    end
    assign s_bus.in_ready  = !w_full;
    assign s_bus.out_valid = !w_empty;
    assign s_bus.out_res   = r_res[r_rd];
    assign s_bus.out_sub   = r_sub[r_rd];
    assign s_bus.out_err   = r_err[r_rd];
    assign s_bus.err_count = r_errs;
endmodule

// File: tb/tb_mod_reduce_stage.sv
// tb_mod_reduce_stage: checks mod_reduce_stage against a queue-based reference model.
// The bench runs a table of vectors, hand-written corner sequences and random traffic.
module tb_mod_reduce_stage;
    localparam int MOD   = 13;
    localparam int DEPTH = 4;
    typedef struct {
        logic [3:0] res;
        logic       sub;
        logic       err;
    } ent_t;
    typedef struct {
        logic [4:0] sum;
        logic       sub;
        logic [3:0] exp_res;
        logic       exp_err;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    ent_t q[$];
    int   m_errs = 0;
    vec_t vecs[10];
    mod_reduce_stage_if bus ();
    mod_reduce_stage #(.MOD(MOD), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_bus(bus.slave)
    );
    always #5 clk = ~clk;
    function automatic ent_t ref_reduce(input int s, input logic sub);
        ent_t e;
        e.sub = sub;
        e.err = s >= 2 * MOD;
        e.res = e.err ? 4'd0 : (s >= MOD) ? 4'(s - MOD) : 4'(s);
        return e;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic chk_model();
        chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
        chk("in_ready", int'(bus.in_ready), int'(q.size() < DEPTH));
        chk("err_count", int'(bus.err_count), m_errs);
        if (q.size() != 0) begin
            chk("out_res", int'(bus.out_res), int'(q[0].res));
            chk("out_sub", int'(bus.out_sub), int'(q[0].sub));
            chk("out_err", int'(bus.out_err), int'(q[0].err));
        end
    endtask
    // Called at a negedge: drive, let one rising edge pass, update the model, then check at the next negedge.
    task automatic step(input logic v, input int sum, input logic sub, input logic ordy);
        logic m_push;
        logic m_pop;
        ent_t e;
        bus.in_valid  = v;
        bus.in_sum    = 5'(sum);
        bus.in_sub    = sub;
        bus.out_ready = ordy;
        m_push = v && q.size() < DEPTH;
        m_pop  = ordy && q.size() != 0;
        e = ref_reduce(sum, sub);
        @(posedge clk);
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
            q.push_back(e);
            if (e.err && m_errs < 255) m_errs++;
        end
        @(negedge clk);
        chk_model();
    endtask
    initial begin
        vecs[0] = '{5'd9,  1'b0, 4'd9,  1'b0};
        vecs[1] = '{5'd20, 1'b1, 4'd7,  1'b0};
        vecs[2] = '{5'd13, 1'b0, 4'd0,  1'b0};
        vecs[3] = '{5'd12, 1'b1, 4'd12, 1'b0};
        vecs[4] = '{5'd26, 1'b0, 4'd0,  1'b1};
        vecs[5] = '{5'd31, 1'b1, 4'd0,  1'b1};
        vecs[6] = '{5'd0,  1'b0, 4'd0,  1'b0};
        vecs[7] = '{5'd25, 1'b0, 4'd12, 1'b0};
        vecs[8] = '{5'd14, 1'b1, 4'd1,  1'b0};
        vecs[9] = '{5'd24, 1'b0, 4'd11, 1'b0};
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset err_count", int'(bus.err_count), 0);
        // Each vector is pushed into an empty FIFO, compared with its table entry, then popped.
        foreach (vecs[i]) begin
            step(1'b1, int'(vecs[i].sum), vecs[i].sub, 1'b0);
            chk("vec valid", int'(bus.out_valid), 1);
            chk("vec res", int'(bus.out_res), int'(vecs[i].exp_res));
            chk("vec err", int'(bus.out_err), int'(vecs[i].exp_err));
            chk("vec sub", int'(bus.out_sub), int'(vecs[i].sub));
            step(1'b0, 0, 1'b0, 1'b1);
            chk("vec drained", int'(bus.out_valid), 0);
        end
        chk("two errors", int'(bus.err_count), 2);
        for (int i = 0; i < 300; i++) step(1'b1, 26 + (i % 6), i[0], 1'b1);
        chk("err saturate", int'(bus.err_count), 255);
        step(1'b0, 0, 1'b0, 1'b1);
        // Fill with out_ready low; sum 5 must wait until the slot freed by a pop is visible.
        for (int i = 1; i <= 5; i++) step(1'b1, i, 1'b0, 1'b0);
        chk("full in_ready", int'(bus.in_ready), 0);
        chk("full head", int'(bus.out_res), 1);
        step(1'b1, 5, 1'b0, 1'b1);
        chk("pop no push", int'(q.size()), 3);
        chk("ready after pop", int'(bus.in_ready), 1);
        chk("second head", int'(bus.out_res), 2);
        step(1'b1, 5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 1'b1);
        chk("drained after 5", int'(bus.out_valid), 0);
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2 + i, 1'b0, 1'b1);
            chk("steady occupancy", int'(q.size()), 2);
            chk("steady head", int'(bus.out_res), i + 1);
        end
        repeat (3) step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
        rst = 1'b1;
        q.delete();
        m_errs = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 30, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, i + 3, 1'b0, 1'b0);
        chk("pre-reset occupancy", int'(q.size()), 3);
        chk("pre-reset err_count", int'(bus.err_count), 5);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", int'(bus.out_valid), 0);
        chk("async err_count", int'(bus.err_count), 0);
        q.delete();
        m_errs = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("release in_ready", int'(bus.in_ready), 1);
        chk("release out_valid", int'(bus.out_valid), 0);
        step(1'b1, 14, 1'b0, 1'b0);
        chk("post-reset res", int'(bus.out_res), 1);
        chk("post-reset valid", int'(bus.out_valid), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
